// File: rtl/top_clk_v3.sv
// Real-time clock core: prescales the system clock to a one-second tick and
// keeps elapsed seconds and minutes as registered 6-bit binary counts.
module top_clk_v3 #(
    parameter int CLK_DIV = 100000000,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    output logic [5:0] seconds_out,
    output logic [5:0] minutes_out
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [5:0]       SEC_LAST = 6'(SEC_MAX);
    localparam logic [5:0]       MIN_LAST = 6'(MIN_MAX);

    logic [CNT_W-1:0] pre_q;
    logic [CNT_W-1:0] pre_d;
    logic [5:0]       sec_q;
    logic [5:0]       sec_d;
    logic [5:0]       min_q;
    logic [5:0]       min_d;
    logic             tick_s;
    logic             carry_s;

    // Prescaler next state and one-second tick (held low while in reset).
    always_comb begin
        pre_d  = pre_q;
        tick_s = 1'b0;
        if (reset && (pre_q >= CNT_LAST)) begin
            tick_s = 1'b1;
            pre_d  = '0;
        end else begin
            tick_s = 1'b0;
            pre_d  = pre_q + CNT_ONE;
        end
    end

    // Seconds and minutes next state; the >= compares also pull any
    // out-of-range value back to zero so 60..63 cannot persist.
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        carry_s = 1'b0;
        if (tick_s) begin
            if (sec_q >= SEC_LAST) begin
                sec_d   = 6'd0;
                carry_s = 1'b1;
            end else begin
                sec_d   = sec_q + 6'd1;
                carry_s = 1'b0;
            end
        end else begin
            sec_d   = sec_q;
            carry_s = 1'b0;
        end
        if (carry_s) begin
            if (min_q >= MIN_LAST) begin
                min_d = 6'd0;
            end else begin
                min_d = min_q + 6'd1;
            end
        end else begin
            min_d = min_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q <= '0;
            sec_q <= 6'd0;
            min_q <= 6'd0;
        end else begin
            pre_q <= pre_d;
            sec_q <= sec_d;
            min_q <= min_d;
        end
    end

    assign seconds_out = sec_q;
    assign minutes_out = min_q;

endmodule

// File: tb/tb_top_clk_v3.sv
// Bench for top_clk_v3: a CLK_DIV=10 instance and a CLK_DIV=1 instance,
// checked against an elapsed-cycle model via a scoreboard plus a checkpoint table.
module tb_top_clk_v3;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [5:0] sec_a;
    logic [5:0] min_a;
    logic [5:0] sec_b;
    logic [5:0] min_b;

    int tests;
    int fails;
    int na;
    int nb;
    int bad_range;

    typedef struct {
        bit         is_b;
        int         cyc;
        logic [5:0] sec;
        logic [5:0] min;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        int         n;
        logic [5:0] sec;
        logic [5:0] min;
    } vec_t;

    vec_t vecs[12];

    top_clk_v3 #(.CLK_DIV(10), .SEC_MAX(59), .MIN_MAX(59)) dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .seconds_out (sec_a),
        .minutes_out (min_a)
    );

    top_clk_v3 #(.CLK_DIV(1), .SEC_MAX(59), .MIN_MAX(59)) dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .seconds_out (sec_b),
        .minutes_out (min_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act_s, input int act_m,
                         input int exp_s, input int exp_m);
        tests++;
        if (act_s != exp_s || act_m != exp_m) begin
            fails++;
            $display("FAIL %s: got %0d:%0d expected %0d:%0d", name, act_m, act_s, exp_m, exp_s);
        end
    endtask

    // One clock edge: update models, push expectations, clock, pop and compare.
    task automatic step(input logic ra, input logic rb, input bit ca, input bit cb);
        exp_t e;
        rst_a = ra;
        rst_b = rb;
        na = ra ? na + 1 : 0;
        nb = rb ? nb + 1 : 0;
        if (ca) begin
            e.is_b = 1'b0; e.cyc = na;
            e.sec = 6'((na / 10) % 60);
            e.min = 6'((na / 600) % 60);
            sb_q.push_back(e);
        end
        if (cb) begin
            e.is_b = 1'b1; e.cyc = nb;
            e.sec = 6'(nb % 60);
            e.min = 6'((nb / 60) % 60);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sec_a > 6'd59 || min_a > 6'd59 || sec_b > 6'd59 || min_b > 6'd59) bad_range++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.is_b) check($sformatf("div1_cyc%0d", e.cyc), sec_b, min_b, e.sec, e.min);
            else        check($sformatf("div10_cyc%0d", e.cyc), sec_a, min_a, e.sec, e.min);
        end
    endtask

    initial begin
        tests = 0; fails = 0; na = 0; nb = 0; bad_range = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;

        vecs[0]  = '{9,     6'd0,  6'd0};
        vecs[1]  = '{10,    6'd1,  6'd0};
        vecs[2]  = '{19,    6'd1,  6'd0};
        vecs[3]  = '{20,    6'd2,  6'd0};
        vecs[4]  = '{599,   6'd59, 6'd0};
        vecs[5]  = '{600,   6'd0,  6'd1};
        vecs[6]  = '{601,   6'd0,  6'd1};
        vecs[7]  = '{3599,  6'd59, 6'd5};
        vecs[8]  = '{3600,  6'd0,  6'd6};
        vecs[9]  = '{35999, 6'd59, 6'd59};
        vecs[10] = '{36000, 6'd0,  6'd0};
        vecs[11] = '{36010, 6'd1,  6'd0};

        // Held reset: outputs stay zero every cycle.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_hold_a", sec_a, min_a, 0, 0);

        // Release and run through the full hour wrap, checking table checkpoints.
        for (int v = 0; v < 12; v++) begin
            while (na < vecs[v].n) begin
                step(1'b1, 1'b0, (na < 620) || (na % 10 == 9) || (na >= 35985), 1'b0);
            end
            check($sformatf("table_n%0d", vecs[v].n), sec_a, min_a, vecs[v].sec, vecs[v].min);
        end

        // Mid-prescale reset at 00:37.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        while (na < 375) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_reset_0037", sec_a, min_a, 37, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_mid_count", sec_a, min_a, 0, 0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("after_reset_edge9", sec_a, min_a, 0, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("after_reset_edge10", sec_a, min_a, 1, 0);

        // CLK_DIV=1 instance: increments every cycle, minute after 60.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("div1_after65", sec_b, min_b, 5, 1);

        tests++;
        if (bad_range != 0) begin
            fails++;
            $display("FAIL range: %0d cycles with value above 59, required 0", bad_range);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/top_clk_v3.md
Name: top_clk_v3

Overview:
- Real-time clock core: divides the 100 MHz system clock down to a 1 Hz tick and keeps elapsed time as seconds (0-59) and minutes (0-59).
- Top of the clock subsystem. Internally: prescaler, seconds counter, minutes counter.
- Both counts are presented as registered 6-bit binary outputs for downstream display/decoding logic.

Parameters:
- CLK_DIV, 100000000, clock cycles per one-second tick; legal range >= 1; benches override it with a small value, e.g. 10.
- SEC_MAX, 59, terminal value of the seconds counter.
- MIN_MAX, 59, terminal value of the minutes counter.

Ports:
- clk  input  1  system clock, 100 MHz; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on the rising edge of clk).
- seconds_out  output  6  current seconds, binary 0..SEC_MAX.
- minutes_out  output  6  current minutes, binary 0..MIN_MAX.
- Port order, for positional instantiation: clk, reset, seconds_out, minutes_out.

Behaviour:
- One clock domain, fully synchronous. No asynchronous paths. Outputs are driven directly from registers, with no combinational logic from inputs.

Reset:
- On any rising edge with reset=0: prescaler count = 0, seconds_out = 0, minutes_out = 0, internal tick = 0.
- Reset asserted mid-count clears everything on that edge, regardless of tick or wrap.
- Reset has priority over all other events.

Prescaler:
- Counter width ceil(log2(CLK_DIV)), minimum 1 bit.
- Counts 0..CLK_DIV-1, then wraps to 0.
- tick = 1 for exactly one cycle whenever the count equals CLK_DIV-1.
- If CLK_DIV = 1, tick is 1 on every non-reset cycle.

Seconds counter:
- Advances by 1 on each cycle where tick = 1.
- When it is at SEC_MAX and tick = 1, it wraps to 0 and asserts carry for that cycle.

Minutes counter:
- Advances by 1 on each seconds carry.
- When it is at MIN_MAX and a carry occurs, it wraps to 0. There is no hour output; the full wrap is silent.

Update timing:
- Seconds wrap and minutes increment happen on the same clock edge, so 00:59 goes to 01:00 atomically with no intermediate value visible.
- At 59:59 plus one tick, both outputs go to 0 on the same edge.

Latency:
- After reset is released (first edge with reset=1 counts as prescaler cycle 1), seconds_out becomes 1 on the CLK_DIV-th rising edge with reset=1.
- Thereafter seconds_out changes every CLK_DIV cycles.

Value range:
- Outputs never exceed SEC_MAX or MIN_MAX.
- Values 60-63 are unreachable and must not appear.
- Arithmetic is unsigned, 6 bits.

Test Plan:
1. CLK_DIV=10, hold reset=0 for 10 cycles -> seconds_out=0 and minutes_out=0 throughout; prescaler is idle.
2. CLK_DIV=10, release reset -> seconds_out=1 at the 10th edge after release, 2 at the 20th; stable between ticks.
3. CLK_DIV=10, run 600 cycles from reset -> seconds_out goes 59 to 0 and minutes_out goes 0 to 1 on the same edge (cycle 600); minutes_out=1, seconds_out=0 afterwards.
4. CLK_DIV=10, run 36000 cycles -> on the 59:59 to 00:00 transition both outputs read 0 on the same edge; no value above 59 ever observed.
5. CLK_DIV=10, assert reset=0 for one cycle at time 00:37 mid-prescale -> next edge gives 00:00; after release, the next increment occurs exactly 10 edges later.
6. CLK_DIV=1 -> seconds_out increments every cycle after reset release; minutes_out=1 after 60 cycles.
